// File: rtl/renas_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : renas_write_buffer
//  Description : Posted-write FIFO between the data cache and the AHB path to
//                main memory. Each entry drains as a single-beat AHB write.
//                Optional read forwarding is enabled with RENAS_WB_FWD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module renas_write_buffer #(
    parameter int DATA_LENGTH = 32,
    parameter int ADDR_LENGTH = 32,
    parameter int WB_DEPTH    = 4
) (
    input  logic                   clk_l2,
    input  logic                   rst_n,
    // cache push side
    input  logic                   wb_req,
    input  logic [ADDR_LENGTH-1:0] wb_addr,
    input  logic [DATA_LENGTH-1:0] wb_data,
    output logic                   wb_ack,
    output logic                   full_flag,
    output logic                   empty_flag,
    // forwarding lookup
    input  logic                   rd_req,
    input  logic [ADDR_LENGTH-1:0] rd_addr,
    output logic                   rd_hit,
    output logic [DATA_LENGTH-1:0] rd_data,
    // AHB master
    output logic [1:0]             m_htrans,
    output logic [ADDR_LENGTH-1:0] m_haddr,
    output logic                   m_hwrite,
    output logic [2:0]             m_hsize,
    output logic [DATA_LENGTH-1:0] m_hwdata,
    input  logic                   m_hready
);

    localparam int         PTR_W         = $clog2(WB_DEPTH);
    localparam int         CNT_W         = PTR_W + 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [ADDR_LENGTH-1:0] addr_mem [WB_DEPTH];
    logic [DATA_LENGTH-1:0] data_mem [WB_DEPTH];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    logic                   push;
    logic                   pop;

    assign full_flag  = (count_q == CNT_W'(WB_DEPTH));
    assign empty_flag = (count_q == '0);
    // Full is judged on the pre-edge count, so a full buffer refuses a push
    // even in the cycle its head pops.
    assign push       = wb_req && !full_flag;
    assign pop        = (state_q == ST_DATA) && m_hready;

    // Storage needs no reset: only entries inside [head, head+count) are valid.
    always_ff @(posedge clk_l2) begin
        if (push) begin
            addr_mem[tail_q] <= wb_addr;
            data_mem[tail_q] <= wb_data;
        end
    end

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wb_ack  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
            wb_ack  <= push;
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // AHB outputs depend only on the state register and the head entry.
    always_comb begin
        state_d  = state_q;
        m_htrans = HTRANS_IDLE;
        m_haddr  = '0;
        m_hwrite = 1'b0;
        m_hwdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_flag) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_htrans = HTRANS_NONSEQ;
                m_haddr  = addr_mem[head_q];
                m_hwrite = 1'b1;
                if (m_hready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_hwdata = data_mem[head_q];
                if (m_hready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_hsize = HSIZE_WORD;

`ifdef RENAS_WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        fwd_idx = head_q;
        for (int i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (rd_req && (CNT_W'(i) < count_q) && (addr_mem[fwd_idx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = data_mem[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{rd_req, rd_addr};
    assign rd_hit     = 1'b0;
    assign rd_data    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_renas_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_renas_write_buffer
//  Description : Self-checking bench for renas_write_buffer: queue-based model
//                compared every cycle, plus directed literal scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_renas_write_buffer;

    localparam int DEPTH = 4;
`ifdef RENAS_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_l2 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        wb_req;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic        wb_ack;
    logic        full_flag;
    logic        empty_flag;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic [1:0]  m_htrans;
    logic [31:0] m_haddr;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic        m_hready;

    always #5 clk_l2 = ~clk_l2;

    renas_write_buffer #(
        .DATA_LENGTH(32),
        .ADDR_LENGTH(32),
        .WB_DEPTH   (DEPTH)
    ) dut (
        .clk_l2    (clk_l2),
        .rst_n     (rst_n),
        .wb_req    (wb_req),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ack    (wb_ack),
        .full_flag (full_flag),
        .empty_flag(empty_flag),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .m_htrans  (m_htrans),
        .m_haddr   (m_haddr),
        .m_hwrite  (m_hwrite),
        .m_hsize   (m_hsize),
        .m_hwdata  (m_hwdata),
        .m_hready  (m_hready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   mphase = 0;   // 0: no transfer, 1: address phase of head, 2: data phase of head
    logic mack   = 1'b0;

    always @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mphase = 0;
            mack   = 1'b0;
        end else begin
            bit was_full, was_empty, do_push, do_pop;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            do_push   = wb_req && !was_full;
            do_pop    = (mphase == 2) && m_hready;
            if (mphase == 0)      mphase = was_empty ? 0 : 1;
            else if (m_hready)    mphase = (mphase == 1) ? 2 : 0;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({wb_addr, wb_data});
            mack = do_push;
        end
    end

    function automatic void fwd_model(output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (FWD && rd_req) begin
            foreach (mq[i]) begin
                if (mq[i].a == rd_addr) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                end
            end
        end
    endfunction

    always @(negedge clk_l2) begin
        logic        exp_hit;
        logic [31:0] exp_rd;
        fwd_model(exp_hit, exp_rd);
        check("cmp_wb_ack", wb_ack, mack);
        check("cmp_full", full_flag, mq.size() == DEPTH);
        check("cmp_empty", empty_flag, mq.size() == 0);
        check("cmp_htrans", m_htrans, (mphase == 1) ? 2'b10 : 2'b00);
        check("cmp_haddr", m_haddr, (mphase == 1) ? mq[0].a : 32'h0);
        check("cmp_hwrite", m_hwrite, mphase == 1);
        check("cmp_hwdata", m_hwdata, (mphase == 2) ? mq[0].d : 32'h0);
        check("cmp_hsize", m_hsize, 3'b010);
        check("cmp_rd_hit", rd_hit, exp_hit);
        check("cmp_rd_data", rd_data, exp_rd);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk_l2);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got[$];
        bit          acked;
        bit          found;

        wb_req   = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        m_hready = 1'b1;
        rst_n    = 1'b0;
        repeat (3) cyc();

        check("rst_wb_ack", wb_ack, 0);
        check("rst_full", full_flag, 0);
        check("rst_empty", empty_flag, 1);
        check("rst_rd_hit", rd_hit, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_htrans", m_htrans, 2'b00);
        check("rst_haddr", m_haddr, 0);
        check("rst_hwrite", m_hwrite, 0);
        check("rst_hwdata", m_hwdata, 0);
        check("rst_hsize", m_hsize, 3'b010);
        rst_n = 1'b1;

        // single push and drain
        wb_req = 1'b1; wb_addr = 32'h0000_0800; wb_data = 32'hDEAD_BEEF;
        cyc();
        check("t1_ack", wb_ack, 1);
        check("t1_not_empty", empty_flag, 0);
        wb_req = 1'b0;
        cyc();
        check("t1_nonseq", m_htrans, 2'b10);
        check("t1_haddr", m_haddr, 32'h800);
        check("t1_ack_pulse", wb_ack, 0);
        cyc();
        check("t1_data_idle", m_htrans, 2'b00);
        check("t1_hwdata", m_hwdata, 32'hDEAD_BEEF);
        cyc();
        check("t1_empty", empty_flag, 1);
        check("t1_hwdata_clr", m_hwdata, 0);

        // fill while stalled, fifth push refused
        m_hready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wb_req = 1'b1; wb_addr = 32'h900 + 32'(4 * k); wb_data = 32'h100 + 32'(k);
            cyc();
            check("t2_ack", wb_ack, 1);
        end
        check("t2_full", full_flag, 1);
        wb_addr = 32'h910; wb_data = 32'h104;
        cyc();
        check("t2_no_ack", wb_ack, 0);
        cyc();
        check("t2_no_ack2", wb_ack, 0);
        check("t2_still_full", full_flag, 1);
        check("t2_addr_held", m_haddr, 32'h900);
        got.delete();
        got.push_back(m_haddr);
        acked    = 1'b0;
        m_hready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            cyc();
            if (wb_ack) begin
                acked  = 1'b1;
                wb_req = 1'b0;
            end
            if (m_htrans == 2'b10) got.push_back(m_haddr);
            if (got.size() >= 5 && empty_flag && !wb_req) break;
        end
        check("t2_fifth_acked", acked, 1);
        check("t2_drain_count", got.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check("t2_order", (k < got.size()) ? got[k] : 32'hFFFF_FFFF, 32'h900 + 32'(4 * k));
        end
        wb_req = 1'b0;

        // DATA phase wait states
        wb_req = 1'b1; wb_addr = 32'hB00; wb_data = 32'hCAFE_F00D;
        cyc();
        wb_req = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            cyc();
            if (m_htrans == 2'b10) found = 1'b1;
        end
        check("t3_addr_seen", found, 1);
        cyc();
        check("t3_hwdata", m_hwdata, 32'hCAFE_F00D);
        m_hready = 1'b0;
        repeat (3) begin
            cyc();
            check("t3_hwdata_held", m_hwdata, 32'hCAFE_F00D);
            check("t3_no_pop", empty_flag, 0);
        end
        m_hready = 1'b1;
        cyc();
        check("t3_popped", empty_flag, 1);

        // forwarding, youngest wins
        m_hready = 1'b0;
        wb_req = 1'b1; wb_addr = 32'hA00; wb_data = 32'h1111;
        cyc();
        wb_data = 32'h2222;
        cyc();
        wb_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 32'hA00;
        #1;
        check("t4_hit", rd_hit, FWD);
        check("t4_data", rd_data, FWD ? 32'h2222 : 32'h0);
        rd_addr = 32'hA04;
        #1;
        check("t4_miss", rd_hit, 0);
        check("t4_miss_data", rd_data, 0);
        rd_req   = 1'b0;
        m_hready = 1'b1;
        for (int n = 0; n < 40 && !empty_flag; n++) cyc();
        check("t4_drained", empty_flag, 1);

        // reset during an address phase
        m_hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wb_req = 1'b1; wb_addr = 32'hC00 + 32'(4 * k); wb_data = 32'h300 + 32'(k);
            cyc();
        end
        wb_req = 1'b0;
        check("t5_pre_nonseq", m_htrans, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_htrans_idle", m_htrans, 2'b00);
        check("t5_empty", empty_flag, 1);
        check("t5_haddr", m_haddr, 0);
        cyc();
        rst_n    = 1'b1;
        m_hready = 1'b1;
        repeat (8) begin
            cyc();
            check("t5_no_stale", m_htrans, 2'b00);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            wb_req   = ($urandom_range(0, 99) < 45);
            wb_addr  = 32'hD00 + 32'(4 * $urandom_range(0, 5));
            wb_data  = $urandom;
            rd_req   = ($urandom_range(0, 1) == 1);
            rd_addr  = 32'hD00 + 32'(4 * $urandom_range(0, 6));
            m_hready = ($urandom_range(0, 99) < 65);
            cyc();
        end
        wb_req   = 1'b0;
        rd_req   = 1'b0;
        m_hready = 1'b1;
        for (int n = 0; n < 60 && !empty_flag; n++) cyc();
        check("rand_drained", empty_flag, 1);
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/renas_write_buffer.md
# renas_write_buffer

Posted-write buffer between the RVS192 data cache and the D-side AHB path into `renas_memory`. It accepts dirty-word write-backs from the cache in one cycle and stores them in a small FIFO. It drains them in order as single-beat AHB write transfers, so cache evictions never stall on main-memory latency. An optional forwarding port lets the cache read data that is still pending in the buffer.

## Interface
- `DATA_LENGTH`, 32, data width in bits
- `ADDR_LENGTH`, 32, address width in bits
- `WB_DEPTH`, 4, number of FIFO entries; power of two, ≥2

- `clk_l2`  in  1  single clock; same domain as the memory AHB interface
- `rst_n`  in  1  reset, asynchronous, active-low
- `wb_req`  in  1  cache push request
- `wb_addr`  in  ADDR_LENGTH  byte address of the word to write; bits [1:0] are always 0
- `wb_data`  in  DATA_LENGTH  write data
- `wb_ack`  out  1  one-cycle pulse, registered, the cycle after a push is accepted
- `full_flag`  out  1  count == WB_DEPTH
- `empty_flag`  out  1  count == 0
- `rd_req`  in  1  forwarding lookup strobe
- `rd_addr`  in  ADDR_LENGTH  lookup address
- `rd_hit`  out  1  a pending entry matches `rd_addr`
- `rd_data`  out  DATA_LENGTH  data of the matching entry
- `m_htrans`  out  2  AHB HTRANS: 2'b00 IDLE or 2'b10 NONSEQ
- `m_haddr`  out  ADDR_LENGTH  AHB address
- `m_hwrite`  out  1  AHB write
- `m_hsize`  out  3  constant 3'b010 (word)
- `m_hwdata`  out  DATA_LENGTH  AHB write data
- `m_hready`  in  1  AHB HREADY from the slave

## Operation
- **FIFO**
  - Circular storage with head pointer, tail pointer and count register.
  - Pointers are log2(WB_DEPTH) bits and wrap naturally.
  - `count` is log2(WB_DEPTH)+1 bits.
- **Push**
  - A push is accepted at a rising edge when `wb_req && !full_flag`.
  - The entry {`wb_addr`, `wb_data`} is written at the tail and the tail advances.
  - `wb_ack` goes high for the next cycle only.
  - A push while full is dropped and gives no `wb_ack`; the cache holds `wb_req` until it is acked.
- **Drain FSM**
  - States: IDLE, ADDR, DATA.
  - IDLE → ADDR when `!empty_flag`.
  - ADDR: `m_htrans`=NONSEQ, `m_haddr`=head address, `m_hwrite`=1. When `m_hready`=1 → DATA; otherwise stay in ADDR with outputs held.
  - DATA: `m_htrans`=IDLE, `m_hwdata`=head data, `m_hwrite`=0. When `m_hready`=1, pop the head and go to IDLE; otherwise stay in DATA with `m_hwdata` held.
  - Outside ADDR, `m_haddr`=0. Outside DATA, `m_hwdata`=0.
  - All AHB outputs decode from the state register and the head entry; none decode from inputs.
- **Simultaneous push and pop**: count is unchanged. Full is evaluated on the pre-edge count, so a push is still refused in the cycle a full buffer pops.
- **Ordering**: strictly FIFO. The head entry stays valid, and visible to forwarding, until its DATA phase completes.
- **Reset mid-operation**: all entries are discarded, the FSM goes to IDLE and `m_htrans` goes to IDLE immediately. An in-flight AHB transfer is abandoned.
- **Reset values**:
  - `wb_ack`=0, `full_flag`=0, `empty_flag`=1
  - `rd_hit`=0, `rd_data`=0
  - `m_htrans`=2'b00, `m_haddr`=0, `m_hwrite`=0, `m_hwdata`=0, `m_hsize`=3'b010

## Timing
- A push at edge E0 gives `wb_ack` high during E0..E1 and `empty_flag` low after E0.
- The FSM reaches ADDR after E1, DATA after E2 (with `m_hready`=1), and pops at E3.
- Minimum drain rate is 3 cycles per entry; each wait state adds 1 cycle.
- `full_flag` and `empty_flag` are combinational from `count`.
- `rd_hit` and `rd_data` are combinational in the same cycle as `rd_req`.

## Configuration
- Macro: `RENAS_WB_FWD_EN`
- **Defined**:
  - `rd_hit` = `rd_req` && any valid entry has address == `rd_addr`.
  - When several entries match, the youngest (closest to tail) wins for `rd_data`.
  - `rd_data` = 0 when there is no hit.
- **Undefined**:
  - No comparators are built.
  - `rd_hit` and `rd_data` are tied to 0; `rd_req` and `rd_addr` are ignored.

## Test plan
- After reset, with `m_hready`=1: push {0x0000_0800, 0xDEAD_BEEF}. Expect `wb_ack` one cycle later, then NONSEQ with `m_haddr`=0x800 two cycles after the push, then `m_hwdata`=0xDEADBEEF in the following cycle, then `empty_flag`=1.
- Hold `m_hready`=0 and push 5 words, 0x900, 0x904, 0x908, 0x90C, 0x910. The first 4 are acked, `full_flag`=1, and the 5th gets no ack. Release `m_hready`: the writes drain in order 0x900..0x90C and the 5th push is then acked.
- Stall DATA with `m_hready`=0 for 3 cycles. `m_hwdata` is held stable and no pop occurs until `m_hready`=1.
- With `RENAS_WB_FWD_EN`: push 0xA00=0x1111, then 0xA00=0x2222; lookup `rd_addr`=0xA00 gives `rd_hit`=1, `rd_data`=0x2222. Lookup 0xA04 gives `rd_hit`=0. Without the macro, `rd_hit` stays 0.
- Assert `rst_n`=0 during an ADDR phase with 3 entries pending. `m_htrans`=IDLE immediately and `empty_flag`=1; after release, no stale transfer is issued.
